// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: operation names, the stored
// entry layout, and the CDB wakeup rule. The rule is used both for stored
// entries and for an instruction being inserted.
package reservation_station_pkg;

   // Widths are package-wide because every unit sees the same issue bus and CDB.
   localparam int TAG_W = 6;
   localparam int XLEN  = 32;

   typedef enum logic [3:0] {
      INSTR_NOP, INSTR_ADD, INSTR_SUB, INSTR_AND,
      INSTR_OR,  INSTR_XOR, INSTR_SLL, INSTR_SRL,
      INSTR_SRA, INSTR_SLT, INSTR_LW,  INSTR_SW,
      INSTR_BEQ, INSTR_BNE, INSTR_JAL, INSTR_JALR
   } instr_name_e;

   typedef struct packed {
      logic              valid;
      instr_name_e       instr_name;
      logic [XLEN-1:0]   address;
      logic [XLEN-1:0]   immediate;
      logic [XLEN-1:0]   data_1;
      logic [XLEN-1:0]   data_2;
      logic              valid_1;
      logic              valid_2;
      logic [TAG_W-1:0]  tag_1;
      logic [TAG_W-1:0]  tag_2;
      logic [TAG_W-1:0]  dst_tag;
   } rs_entry_t;

   // Captures a CDB broadcast into every waiting operand whose producer tag matches.
   // Both operands can be woken by the same broadcast.
   function automatic rs_entry_t cdb_wakeup(input rs_entry_t        entry,
                                            input logic             cdb_valid,
                                            input logic [TAG_W-1:0] cdb_tag,
                                            input logic [XLEN-1:0]  cdb_data);
      rs_entry_t woken;
      woken = entry;
      if (entry.valid && cdb_valid) begin
         if (!entry.valid_1 && entry.tag_1 == cdb_tag) begin
            woken.data_1  = cdb_data;
            woken.valid_1 = 1'b1;
         end
         if (!entry.valid_2 && entry.tag_2 == cdb_tag) begin
            woken.data_2  = cdb_data;
            woken.valid_2 = 1'b1;
         end
      end
      return woken;
   endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue bus, CDB, and execution-unit handshake of one reservation station.
// The master side is the surrounding pipeline. The slave side is the station.
interface reservation_station_if;
   import reservation_station_pkg::*;

   logic              issue_valid;
   logic [XLEN-1:0]   issue_address;
   logic [XLEN-1:0]   issue_immediate;
   logic [XLEN-1:0]   issue_data_1;
   logic [XLEN-1:0]   issue_data_2;
   logic              issue_valid_1;
   logic              issue_valid_2;
   logic [TAG_W-1:0]  issue_tag_1;
   logic [TAG_W-1:0]  issue_tag_2;
   logic [TAG_W-1:0]  issue_dst_tag;
   instr_name_e       issue_instr_name;
   logic              full;
   logic              empty;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [XLEN-1:0]   cdb_data;

   logic              ex_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   ex_address;
   logic [XLEN-1:0]   ex_immediate;
   logic [XLEN-1:0]   ex_data_1;
   logic [XLEN-1:0]   ex_data_2;
   logic [TAG_W-1:0]  ex_dst_tag;
   instr_name_e       ex_instr_name;

   modport master (
      output issue_valid, issue_address, issue_immediate, issue_data_1, issue_data_2,
             issue_valid_1, issue_valid_2, issue_tag_1, issue_tag_2, issue_dst_tag,
             issue_instr_name, cdb_valid, cdb_tag, cdb_data, ex_ready,
      input  full, empty, ex_valid, ex_address, ex_immediate, ex_data_1, ex_data_2,
             ex_dst_tag, ex_instr_name
   );

   modport slave (
      input  issue_valid, issue_address, issue_immediate, issue_data_1, issue_data_2,
             issue_valid_1, issue_valid_2, issue_tag_1, issue_tag_2, issue_dst_tag,
             issue_instr_name, cdb_valid, cdb_tag, cdb_data, ex_ready,
      output full, empty, ex_valid, ex_address, ex_immediate, ex_data_1, ex_data_2,
             ex_dst_tag, ex_instr_name
   );

endinterface

// File: rtl/reservation_station_select.sv
// Oldest-ready picker. Index 0 is the oldest entry, so the lowest set bit of
// the ready vector wins. The module is purely combinational.
module rs_select #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]         ready,
   output logic [DEPTH-1:0]         onehot,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     any
);

   // Priority scan from the youngest slot down, so the lowest ready index is assigned last.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = ($clog2(DEPTH))'(i);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for one execution unit. Entries are kept compacted in
// age order (slot 0 oldest). Missing operands are captured from the CDB. The
// oldest fully-ready entry is offered to the execution unit over valid/ready.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   input logic                 flush,
   reservation_station_if.slave rs
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   rs_entry_t         entries     [DEPTH];
   rs_entry_t         entries_nxt [DEPTH];
   rs_entry_t         shifted     [DEPTH];
   rs_entry_t         issue_entry;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic [CNT_W-1:0]  ins_pos;
   logic [DEPTH-1:0]  ready_vec;
   logic [DEPTH-1:0]  sel_onehot;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_any;
   logic              full_q;
   logic              remove;
   logic              insert;

   // Status flags come from the registered count only.
   assign full_q   = (count == CNT_W'(DEPTH));
   assign rs.full  = full_q;
   assign rs.empty = (count == '0);

   // An entry is a dispatch candidate once both operands are present.
   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = entries[i].valid && entries[i].valid_1 && entries[i].valid_2;
      end
   end

   rs_select #(.DEPTH(DEPTH)) u_select (
      .ready  (ready_vec),
      .onehot (sel_onehot),
      .idx    (sel_idx),
      .any    (sel_any)
   );

   // The dispatch port is an AND-OR mux over registered entries, so it reads zero when nothing is selected.
   always_comb begin
      rs.ex_valid      = sel_any;
      rs.ex_address    = '0;
      rs.ex_immediate  = '0;
      rs.ex_data_1     = '0;
      rs.ex_data_2     = '0;
      rs.ex_dst_tag    = '0;
      rs.ex_instr_name = INSTR_NOP;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_onehot[i]) begin
            rs.ex_address    = entries[i].address;
            rs.ex_immediate  = entries[i].immediate;
            rs.ex_data_1     = entries[i].data_1;
            rs.ex_data_2     = entries[i].data_2;
            rs.ex_dst_tag    = entries[i].dst_tag;
            rs.ex_instr_name = entries[i].instr_name;
         end
      end
   end

   assign remove  = sel_any && rs.ex_ready;
   // A slot freed by this cycle's dispatch may be refilled in the same cycle.
   assign insert  = rs.issue_valid && (!full_q || remove);
   assign ins_pos = count - CNT_W'(remove);

   // Build the incoming entry. A same-cycle CDB match is captured at issue time.
   always_comb begin
      issue_entry            = '0;
      issue_entry.valid      = 1'b1;
      issue_entry.instr_name = rs.issue_instr_name;
      issue_entry.address    = rs.issue_address;
      issue_entry.immediate  = rs.issue_immediate;
      issue_entry.data_1     = rs.issue_data_1;
      issue_entry.data_2     = rs.issue_data_2;
      issue_entry.valid_1    = rs.issue_valid_1;
      issue_entry.valid_2    = rs.issue_valid_2;
      issue_entry.tag_1      = rs.issue_tag_1;
      issue_entry.tag_2      = rs.issue_tag_2;
      issue_entry.dst_tag    = rs.issue_dst_tag;
      issue_entry            = cdb_wakeup(issue_entry, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
   end

   // Each slot's view of its younger neighbour. The top slot empties when everything shifts down.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         shifted[i] = entries[i + 1];
      end
      shifted[DEPTH-1] = '0;
   end

   // Next state. Removal compaction, wakeup, and insertion combine, and flush overrides all three.
   always_comb begin
      count_nxt = count;
      for (int i = 0; i < DEPTH; i++) begin
         entries_nxt[i] = entries[i];
      end
      if (flush) begin
         count_nxt = '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_nxt[i].valid = 1'b0;
         end
      end else begin
         count_nxt = count + CNT_W'(insert) - CNT_W'(remove);
         for (int i = 0; i < DEPTH; i++) begin
            if (remove && IDX_W'(i) >= sel_idx) begin
               entries_nxt[i] = shifted[i];
            end
            entries_nxt[i] = cdb_wakeup(entries_nxt[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
            if (insert && CNT_W'(i) == ins_pos) begin
               entries_nxt[i] = issue_entry;
            end
         end
      end
   end

   // Entry and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         count <= '0;
         // NOTE: only the valid bits need reset. Payload in an invalid slot is never selected or observed.
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
         end
      end else begin
         count   <= count_nxt;
         entries <= entries_nxt;
      end
   end

   // Simulation-only warning when upstream ignores full and an instruction is dropped.
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         assert (!(rs.issue_valid && full_q && !remove))
            else $warning("reservation_station: issue dropped while full");
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a dispatch scoreboard. Each test
// queues the packets it expects in the order they should leave the station.
// Every accepted handshake pops the queue and compares the dispatched fields.
module tb_reservation_station;
   import reservation_station_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0]  address;
      logic [XLEN-1:0]  immediate;
      logic [XLEN-1:0]  data_1;
      logic [XLEN-1:0]  data_2;
      logic [TAG_W-1:0] dst_tag;
      instr_name_e      instr_name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   reservation_station_if rs_bus();

   reservation_station #(.DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .rs    (rs_bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic exp_t mk(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] d1,
                               input logic [XLEN-1:0] d2, input instr_name_e name);
      exp_t e;
      e.address    = addr;
      e.immediate  = addr ^ 32'h5A5A_0000;
      e.data_1     = d1;
      e.data_2     = d2;
      e.dst_tag    = TAG_W'(addr >> 2);
      e.instr_name = name;
      return e;
   endfunction

   // One clock. A handshake about to be taken is scored before the edge. Returns at the next negedge with one-shot inputs cleared.
   task automatic cycle();
      exp_t want;
      #1;
      if (!reset && !flush && rs_bus.ex_valid && rs_bus.ex_ready) begin
         check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("ex_address",    64'(rs_bus.ex_address),    64'(want.address));
            check("ex_immediate",  64'(rs_bus.ex_immediate),  64'(want.immediate));
            check("ex_data_1",     64'(rs_bus.ex_data_1),     64'(want.data_1));
            check("ex_data_2",     64'(rs_bus.ex_data_2),     64'(want.data_2));
            check("ex_dst_tag",    64'(rs_bus.ex_dst_tag),    64'(want.dst_tag));
            check("ex_instr_name", 64'(rs_bus.ex_instr_name), 64'(want.instr_name));
         end
      end
      @(posedge clk);
      @(negedge clk);
      rs_bus.issue_valid = 1'b0;
      rs_bus.cdb_valid   = 1'b0;
      flush              = 1'b0;
      reset              = 1'b0;
   endtask

   task automatic issue(input logic [XLEN-1:0] addr,
                        input logic [XLEN-1:0] d1, input logic v1, input logic [TAG_W-1:0] t1,
                        input logic [XLEN-1:0] d2, input logic v2, input logic [TAG_W-1:0] t2,
                        input instr_name_e name);
      rs_bus.issue_valid      = 1'b1;
      rs_bus.issue_address    = addr;
      rs_bus.issue_immediate  = addr ^ 32'h5A5A_0000;
      rs_bus.issue_data_1     = d1;
      rs_bus.issue_valid_1    = v1;
      rs_bus.issue_tag_1      = t1;
      rs_bus.issue_data_2     = d2;
      rs_bus.issue_valid_2    = v2;
      rs_bus.issue_tag_2      = t2;
      rs_bus.issue_dst_tag    = TAG_W'(addr >> 2);
      rs_bus.issue_instr_name = name;
   endtask

   task automatic cdb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
      rs_bus.cdb_valid = 1'b1;
      rs_bus.cdb_tag   = tag;
      rs_bus.cdb_data  = data;
   endtask

   initial begin
      int n;
      reset                   = 1'b1;
      flush                   = 1'b0;
      rs_bus.issue_valid      = 1'b0;
      rs_bus.issue_address    = '0;
      rs_bus.issue_immediate  = '0;
      rs_bus.issue_data_1     = '0;
      rs_bus.issue_data_2     = '0;
      rs_bus.issue_valid_1    = 1'b0;
      rs_bus.issue_valid_2    = 1'b0;
      rs_bus.issue_tag_1      = '0;
      rs_bus.issue_tag_2      = '0;
      rs_bus.issue_dst_tag    = '0;
      rs_bus.issue_instr_name = INSTR_NOP;
      rs_bus.cdb_valid        = 1'b0;
      rs_bus.cdb_tag          = '0;
      rs_bus.cdb_data         = '0;
      rs_bus.ex_ready         = 1'b0;

      // Reset state.
      @(negedge clk);
      reset = 1'b1; cycle();
      reset = 1'b1; cycle();
      check("rst_full",     64'(rs_bus.full),      64'd0);
      check("rst_empty",    64'(rs_bus.empty),     64'd1);
      check("rst_ex_valid", 64'(rs_bus.ex_valid),  64'd0);
      check("rst_ex_addr",  64'(rs_bus.ex_address), 64'd0);
      check("rst_ex_data1", 64'(rs_bus.ex_data_1), 64'd0);

      // A ready instruction is offered the cycle after issue and leaves on the next cycle.
      rs_bus.ex_ready = 1'b1;
      exp_q.push_back(mk(32'h100, 32'h11, 32'h22, INSTR_ADD));
      issue(32'h100, 32'h11, 1'b1, '0, 32'h22, 1'b1, '0, INSTR_ADD);
      cycle();
      check("t1_ex_valid", 64'(rs_bus.ex_valid), 64'd1);
      check("t1_empty",    64'(rs_bus.empty),    64'd0);
      cycle();
      check("t1_empty_after",  64'(rs_bus.empty),     64'd1);
      check("t1_ex_valid_off", 64'(rs_bus.ex_valid),  64'd0);
      check("t1_ex_addr_zero", 64'(rs_bus.ex_address), 64'd0);

      // A waiting operand ignores a non-matching broadcast, then wakes on tag 5.
      issue(32'h104, 32'h0, 1'b0, 6'd5, 32'h33, 1'b1, '0, INSTR_SUB);
      cycle();
      check("t2_wait", 64'(rs_bus.ex_valid), 64'd0);
      cdb(6'd6, 32'h0000_0BAD);
      cycle();
      check("t2_nomatch", 64'(rs_bus.ex_valid), 64'd0);
      cdb(6'd5, 32'hDEAD_BEEF);
      exp_q.push_back(mk(32'h104, 32'hDEAD_BEEF, 32'h33, INSTR_SUB));
      cycle();
      check("t2_woken",   64'(rs_bus.ex_valid),  64'd1);
      check("t2_data_1",  64'(rs_bus.ex_data_1), 64'hDEAD_BEEF);
      cycle();
      check("t2_empty",   64'(rs_bus.empty),     64'd1);

      // A broadcast in the issue cycle is captured at insertion.
      cdb(6'd9, 32'h0000_1234);
      issue(32'h108, 32'h44, 1'b1, '0, 32'h0, 1'b0, 6'd9, INSTR_AND);
      exp_q.push_back(mk(32'h108, 32'h44, 32'h1234, INSTR_AND));
      cycle();
      check("t3_ex_valid", 64'(rs_bus.ex_valid),  64'd1);
      check("t3_data_2",   64'(rs_bus.ex_data_2), 64'h1234);
      cycle();
      check("t3_empty",    64'(rs_bus.empty),     64'd1);

      // Fill to DEPTH while stalled. Issue while full is dropped.
      rs_bus.ex_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(32'h200 + 32'(4 * i), 32'(i + 1), 32'(i + 256), INSTR_OR));
         issue(32'h200 + 32'(4 * i), 32'(i + 1), 1'b1, '0, 32'(i + 256), 1'b1, '0, INSTR_OR);
         cycle();
         check("t4_full", 64'(rs_bus.full), 64'(i == 7));
      end
      check("t4_head", 64'(rs_bus.ex_address), 64'h200);
      issue(32'h2F0, 32'h1, 1'b1, '0, 32'h2, 1'b1, '0, INSTR_XOR);
      cycle();
      check("t4_full_hold", 64'(rs_bus.full),       64'd1);
      check("t4_head_hold", 64'(rs_bus.ex_address), 64'h200);
      // Insert while full, allowed because a removal happens in the same cycle.
      rs_bus.ex_ready = 1'b1;
      exp_q.push_back(mk(32'h240, 32'h77, 32'h88, INSTR_SLL));
      issue(32'h240, 32'h77, 1'b1, '0, 32'h88, 1'b1, '0, INSTR_SLL);
      cycle();
      check("t4_full_swap", 64'(rs_bus.full), 64'd1);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         cycle();
         n++;
      end
      check("t4_drain_cycles", 64'(n),               64'd8);
      check("t4_empty",        64'(rs_bus.empty),    64'd1);

      // Younger ready entry bypasses an older waiting one, with wakeup landing in a shifted slot.
      issue(32'h300, 32'h0, 1'b0, 6'd12, 32'h55, 1'b1, '0, INSTR_LW);
      cycle();
      check("t5_a_wait", 64'(rs_bus.ex_valid), 64'd0);
      exp_q.push_back(mk(32'h304, 32'h66, 32'h67, INSTR_SW));
      issue(32'h304, 32'h66, 1'b1, '0, 32'h67, 1'b1, '0, INSTR_SW);
      cycle();
      check("t5_b_valid", 64'(rs_bus.ex_valid),   64'd1);
      check("t5_b_cand",  64'(rs_bus.ex_address), 64'h304);
      rs_bus.ex_ready = 1'b0;
      issue(32'h308, 32'h99, 1'b1, '0, 32'h0, 1'b0, 6'd13, INSTR_BEQ);
      cycle();
      check("t5_stall_valid", 64'(rs_bus.ex_valid),   64'd1);
      check("t5_stall_cand",  64'(rs_bus.ex_address), 64'h304);
      rs_bus.ex_ready = 1'b1;
      cdb(6'd13, 32'h0000_C0DE);
      exp_q.push_back(mk(32'h308, 32'h99, 32'hC0DE, INSTR_BEQ));
      cycle();
      check("t5_c_cand", 64'(rs_bus.ex_address), 64'h308);
      cycle();
      check("t5_a_still_wait", 64'(rs_bus.ex_valid), 64'd0);
      cdb(6'd12, 32'h000A_11CE);
      exp_q.push_back(mk(32'h300, 32'hA11CE, 32'h55, INSTR_LW));
      cycle();
      check("t5_a_cand", 64'(rs_bus.ex_address), 64'h300);
      cycle();
      check("t5_empty", 64'(rs_bus.empty), 64'd1);

      // Flush overrides a simultaneous issue and broadcast.
      rs_bus.ex_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         issue(32'h400 + 32'(4 * i), 32'h1, 1'b1, '0, 32'h2, 1'b1, '0, INSTR_ADD);
         cycle();
      end
      check("t6_loaded", 64'(rs_bus.empty), 64'd0);
      flush = 1'b1;
      issue(32'h500, 32'h1, 1'b0, 6'd3, 32'h2, 1'b1, '0, INSTR_ADD);
      cdb(6'd3, 32'h3333_3333);
      cycle();
      check("t6_flush_empty", 64'(rs_bus.empty),    64'd1);
      check("t6_flush_exv",   64'(rs_bus.ex_valid), 64'd0);
      check("t6_flush_full",  64'(rs_bus.full),     64'd0);
      cycle();
      check("t6_flush_nohold", 64'(rs_bus.empty), 64'd1);

      // Reset in the middle of a stall discards all entries.
      for (int i = 0; i < 3; i++) begin
         issue(32'h600 + 32'(4 * i), 32'h1, 1'b1, '0, 32'h2, 1'b1, '0, INSTR_OR);
         cycle();
      end
      check("t7_loaded", 64'(rs_bus.ex_valid), 64'd1);
      reset = 1'b1;
      issue(32'h700, 32'h1, 1'b1, '0, 32'h2, 1'b1, '0, INSTR_OR);
      cycle();
      check("t7_rst_empty", 64'(rs_bus.empty),      64'd1);
      check("t7_rst_exv",   64'(rs_bus.ex_valid),   64'd0);
      check("t7_rst_addr",  64'(rs_bus.ex_address), 64'd0);
      check("sb_drained",   64'(exp_q.size()),      64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
